// File: rtl/dt_pkg.sv
// -----------------------------------------------------------------------------
// dt_pkg -- shared types and sizes for the stimulus-to-result image loader.
//
// Contents:
//   STI_AW     stimulus ROM address width (1024 words of 16 pixels)
//   RES_AW     result RAM address width (128x128 pixels)
//   IMG_W      image width in pixels
//   WORD_BITS  pixels packed into one stimulus word
//   state_t    loader FSM states (IDLE, FETCH, UNPACK, DONE)
// -----------------------------------------------------------------------------
package dt_pkg;

  localparam int STI_AW    = 10;
  localparam int RES_AW    = 14;
  localparam int IMG_W     = 128;
  localparam int WORD_BITS = 16;
  localparam int BIT_CW    = $clog2(WORD_BITS);

  // Last word of the image and last pixel inside a word.
  localparam logic [STI_AW-1:0] LAST_WORD = '1;
  localparam logic [BIT_CW-1:0] LAST_BIT  = BIT_CW'(WORD_BITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    UNPACK = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/sti_res_loader_if.sv
// -----------------------------------------------------------------------------
// sti_res_loader_if -- bundle of the loader's memory-side and client-side
// signals, so an environment can hand one object to its ROM/RAM/client models.
//
// Signal groups:
//   sti_*  stimulus ROM read port (sti_di updated on negedge while sti_rd=1)
//   res_*  result RAM port (write on posedge, res_di updated on negedge)
//   cl_*   client access port into the result RAM
//
// Modports:
//   loader  the loader's view (drives ROM/RAM requests and the client grant)
//   env     the surrounding memories and client (drive data and requests)
// -----------------------------------------------------------------------------
interface sti_res_loader_if;
  import dt_pkg::*;

  logic                 sti_rd;
  logic [STI_AW-1:0]    sti_addr;
  logic [WORD_BITS-1:0] sti_di;

  logic                 res_wr;
  logic                 res_rd;
  logic [RES_AW-1:0]    res_addr;
  logic [7:0]           res_do;
  logic [7:0]           res_di;

  logic                 cl_req;
  logic                 cl_we;
  logic [RES_AW-1:0]    cl_addr;
  logic [7:0]           cl_wdata;
  logic                 cl_gnt;
  logic [7:0]           cl_rdata;

  modport loader (
    output sti_rd, sti_addr, res_wr, res_rd, res_addr, res_do, cl_gnt, cl_rdata,
    input  sti_di, res_di, cl_req, cl_we, cl_addr, cl_wdata
  );

  modport env (
    input  sti_rd, sti_addr, res_wr, res_rd, res_addr, res_do, cl_gnt, cl_rdata,
    output sti_di, res_di, cl_req, cl_we, cl_addr, cl_wdata
  );

endinterface

// File: rtl/sti_res_loader.sv
// -----------------------------------------------------------------------------
// sti_res_loader -- unpacks a 1024 x 16-bit stimulus ROM into a 128x128 byte
// result RAM, one byte per pixel (FG_VAL for a set bit, BG_VAL for a clear
// bit, MSB of each word = leftmost pixel), and shares the RAM with a client.
//
// Ports:
//   clk, reset         clock (posedge) and asynchronous active-low reset
//   start              begin loading one image (sampled only in IDLE)
//   busy, done         load in progress / one-cycle completion pulse
//   sti_rd, sti_addr   stimulus ROM read request and word address
//   sti_di             stimulus word (updated on negedge while sti_rd=1)
//   res_wr, res_rd     result RAM write / read strobes
//   res_addr, res_do   result RAM address and write data
//   res_di             result RAM read data (updated on negedge)
//   cl_req, cl_we      client request / write-enable
//   cl_addr, cl_wdata  client address / write data
//   cl_gnt, cl_rdata   client grant (combinational) / read data (= res_di)
//   dbg_state          current FSM state, for observation only
//
// Handshake: the loader owns the RAM whenever busy=1. While idle, a client
// access is granted in the same cycle it is requested (cl_gnt = cl_req); a
// granted write lands at the closing posedge, granted read data appears on
// cl_rdata after the negedge and is valid at the closing posedge.
//
// Configuration macro: STI_ZERO_SKIP_EN -- when defined, an all-zero stimulus
// word is not unpacked (1 cycle instead of 17); the RAM is assumed to already
// hold BG_VAL there.
// -----------------------------------------------------------------------------
module sti_res_loader
  import dt_pkg::*;
#(
  parameter logic [7:0] FG_VAL = 8'h01,
  parameter logic [7:0] BG_VAL = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 sti_rd,
  output logic [STI_AW-1:0]    sti_addr,
  input  logic [WORD_BITS-1:0] sti_di,
  output logic                 res_wr,
  output logic                 res_rd,
  output logic [RES_AW-1:0]    res_addr,
  output logic [7:0]           res_do,
  input  logic [7:0]           res_di,
  input  logic                 cl_req,
  input  logic                 cl_we,
  input  logic [RES_AW-1:0]    cl_addr,
  input  logic [7:0]           cl_wdata,
  output logic                 cl_gnt,
  output logic [7:0]           cl_rdata,
  output state_t               dbg_state
);

  state_t               state_q, state_d;
  logic [STI_AW-1:0]    word_q, word_d;
  logic [BIT_CW-1:0]    bit_q, bit_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 sti_rd_q, sti_rd_d;
  logic                 ld_wr_q, ld_wr_d;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bit_d   = bit_q;
    shift_d = shift_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          word_d  = '0;
        end
      end

      FETCH: begin
        shift_d = sti_di;
        bit_d   = '0;
        state_d = UNPACK;
`ifdef STI_ZERO_SKIP_EN
        if (sti_di == '0) begin
          if (word_q == LAST_WORD) begin
            state_d = DONE;
          end else begin
            word_d  = word_q + 1'b1;
            state_d = FETCH;
          end
        end
`endif
      end

      UNPACK: begin
        bit_d = bit_q + 1'b1;
        if (bit_q == LAST_BIT) begin
          // The word index stops at the last word, so it can never wrap.
          if (word_q == LAST_WORD) begin
            state_d = DONE;
          end else begin
            word_d  = word_q + 1'b1;
            state_d = FETCH;
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    sti_rd_d = (state_d == FETCH);
    ld_wr_d  = (state_d == UNPACK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      word_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sti_rd_q <= 1'b0;
      ld_wr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sti_rd_q <= sti_rd_d;
      ld_wr_q  <= ld_wr_d;
    end
  end

  // Client access is only possible while idle and out of reset; the reset
  // term keeps the grant and strobes low for the whole time reset is held.
  logic client_ok;
  assign client_ok = reset & ~busy_q & cl_req;

  assign busy      = busy_q;
  assign done      = done_q;
  assign sti_rd    = sti_rd_q;
  assign sti_addr  = word_q;
  assign cl_gnt    = client_ok;
  assign res_wr    = ld_wr_q | (client_ok & cl_we);
  assign res_rd    = client_ok & ~cl_we;
  assign res_addr  = busy_q ? {word_q, bit_q} : cl_addr;
  assign res_do    = busy_q ? (shift_q[LAST_BIT - bit_q] ? FG_VAL : BG_VAL) : cl_wdata;
  assign cl_rdata  = res_di;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sti_res_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sti_res_loader -- self-checking bench for sti_res_loader.
// A ROM model and a RAM model hang off the interface instance; each load is
// predicted from the image rules (pixel = bit [15-b] of word w at address
// w*16+b) into an expected write queue, an expected latency and an expected
// final image.
// -----------------------------------------------------------------------------
module tb_sti_res_loader;
  import dt_pkg::*;

  localparam logic [7:0] FG     = 8'h01;
  localparam logic [7:0] BG     = 8'h00;
  localparam int         NWORDS = 1024;
  localparam int         NPIX   = 16384;
  localparam int         BUDGET = 20000;

  // ---------------- clock / reset ----------------
  logic   clk   = 1'b0;
  logic   reset = 1'b0;
  logic   start = 1'b0;
  logic   busy;
  logic   done;
  state_t dbg_state;

  always #5 clk = ~clk;

  sti_res_loader_if bus();

  sti_res_loader #(.FG_VAL(FG), .BG_VAL(BG)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .sti_rd    (bus.sti_rd),
    .sti_addr  (bus.sti_addr),
    .sti_di    (bus.sti_di),
    .res_wr    (bus.res_wr),
    .res_rd    (bus.res_rd),
    .res_addr  (bus.res_addr),
    .res_do    (bus.res_do),
    .res_di    (bus.res_di),
    .cl_req    (bus.cl_req),
    .cl_we     (bus.cl_we),
    .cl_addr   (bus.cl_addr),
    .cl_wdata  (bus.cl_wdata),
    .cl_gnt    (bus.cl_gnt),
    .cl_rdata  (bus.cl_rdata),
    .dbg_state (dbg_state)
  );

  // ---------------- memory models ----------------
  logic [15:0] rom     [NWORDS];
  logic [7:0]  res_mem [NPIX];
  logic        mem_clr = 1'b0;

  always @(negedge clk) if (bus.sti_rd === 1'b1) bus.sti_di <= rom[bus.sti_addr];
  always @(negedge clk) if (bus.res_rd === 1'b1) bus.res_di <= res_mem[bus.res_addr];
  always @(posedge clk) begin
    if (mem_clr) foreach (res_mem[i]) res_mem[i] <= BG;
    if (bus.res_wr === 1'b1) res_mem[bus.res_addr] <= bus.res_do;
  end

  // ---------------- scoreboard ----------------
  logic [21:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.cl_req = 1'b1; bus.cl_we = 1'b0; bus.cl_addr = 14'd7; bus.cl_wdata = 8'h00;
    #12;
    checks++; if (busy !== 1'b0)          begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)          begin failures++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (bus.sti_rd !== 1'b0)    begin failures++; $display("FAIL reset_sti_rd got %b want 0", bus.sti_rd); end
    checks++; if (bus.res_wr !== 1'b0)    begin failures++; $display("FAIL reset_res_wr got %b want 0", bus.res_wr); end
    checks++; if (bus.res_rd !== 1'b0)    begin failures++; $display("FAIL reset_res_rd got %b want 0", bus.res_rd); end
    checks++; if (bus.cl_gnt !== 1'b0)    begin failures++; $display("FAIL reset_cl_gnt got %b want 0", bus.cl_gnt); end
    checks++; if (bus.sti_addr !== 10'd0) begin failures++; $display("FAIL reset_sti_addr got %h want 0", bus.sti_addr); end
    bus.cl_req = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_client_rw(input logic [13:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    bus.cl_req = 1'b1; bus.cl_we = 1'b1; bus.cl_addr = addr; bus.cl_wdata = data;
    @(negedge clk); #1;
    checks++; if (bus.cl_gnt !== 1'b1) begin failures++; $display("FAIL cl_wr_gnt got %b want 1", bus.cl_gnt); end
    checks++; if (bus.res_wr !== 1'b1) begin failures++; $display("FAIL cl_wr_strobe got %b want 1", bus.res_wr); end
    @(posedge clk); #1;
    checks++; if (res_mem[addr] !== data) begin failures++; $display("FAIL cl_wr_mem got %h want %h", res_mem[addr], data); end
    bus.cl_we = 1'b0; bus.cl_wdata = 8'hFF;
    @(negedge clk); #1;
    checks++; if (bus.cl_gnt !== 1'b1) begin failures++; $display("FAIL cl_rd_gnt got %b want 1", bus.cl_gnt); end
    checks++; if (bus.res_rd !== 1'b1) begin failures++; $display("FAIL cl_rd_strobe got %b want 1", bus.res_rd); end
    @(posedge clk); #1;
    checks++; if (bus.cl_rdata !== data) begin failures++; $display("FAIL cl_rdata got %h want %h", bus.cl_rdata, data); end
    bus.cl_req = 1'b0;
  endtask

  // Runs one full load from the current rom[] contents and checks every RAM
  // write, the done latency, the post-load state and the final image. If the
  // caller leaves cl_req asserted, the start-cycle grant is checked too.
  task automatic run_load(input string name, input int glitch_at);
    int cyc, exp_lat, wr_bad, unexp, blk_bad, pix_bad, first_pix;
    bit d, timed_out, cl_at_start;
    logic [21:0] e, bad_got, bad_exp;
    logic [7:0] want;

    exp_q.delete();
    exp_lat = 1;
    for (int w = 0; w < NWORDS; w++) begin
`ifdef STI_ZERO_SKIP_EN
      if (rom[w] == 16'h0000) begin exp_lat += 1; continue; end
`endif
      exp_lat += 17;
      for (int b = 0; b < 16; b++) exp_q.push_back({14'(w * 16 + b), rom[w][15 - b] ? FG : BG});
    end

    @(posedge clk); #1 mem_clr = 1'b1;
    @(posedge clk); #1 mem_clr = 1'b0;
    start = 1'b1;
    cl_at_start = bus.cl_req;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s idle_busy got %b want 0", name, busy); end
    if (cl_at_start) begin
      checks++; if (bus.cl_gnt !== 1'b1) begin failures++; $display("FAIL %s start_gnt got %b want 1", name, bus.cl_gnt); end
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1 || bus.sti_rd !== 1'b1) begin
      failures++; $display("FAIL %s enter_fetch got busy=%b sti_rd=%b want 1/1", name, busy, bus.sti_rd); end
    if (cl_at_start) begin
      checks++; if (res_mem[bus.cl_addr] !== bus.cl_wdata) begin
        failures++; $display("FAIL %s start_cl_write got %h want %h", name, res_mem[bus.cl_addr], bus.cl_wdata); end
    end

    cyc = 0; wr_bad = 0; unexp = 0; blk_bad = 0; timed_out = 1'b1;
    bad_got = '0; bad_exp = '0;
    while (cyc < BUDGET) begin
      @(negedge clk);
      d = done;
      if (busy === 1'b1) begin
        if (bus.cl_gnt !== 1'b0 || bus.res_rd !== 1'b0) blk_bad++;
        if (bus.res_wr === 1'b1) begin
          if (exp_q.size() == 0) unexp++;
          else begin
            e = exp_q.pop_front();
            if ({bus.res_addr, bus.res_do} !== e) begin
              if (wr_bad == 0) begin bad_got = {bus.res_addr, bus.res_do}; bad_exp = e; end
              wr_bad++;
            end
          end
        end
      end
      start = (cyc == glitch_at);
      @(posedge clk);
      cyc++;
      if (d) begin timed_out = 1'b0; break; end
    end
    start = 1'b0;
    #1;

    checks++; if (timed_out) begin failures++; $display("FAIL %s done_timeout got none want done within %0d", name, BUDGET); end
    checks++; if (cyc !== exp_lat) begin failures++; $display("FAIL %s done_latency got %0d want %0d", name, cyc, exp_lat); end
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL %s after_done got done=%b busy=%b want 0/0", name, done, busy); end
    checks++; if (wr_bad != 0) begin
      failures++; $display("FAIL %s write_seq got %h want %h (%0d bad)", name, bad_got, bad_exp, wr_bad); end
    checks++; if (unexp != 0 || exp_q.size() != 0) begin
      failures++; $display("FAIL %s write_count got extra=%0d missing=%0d want 0/0", name, unexp, exp_q.size()); end
    checks++; if (blk_bad != 0) begin
      failures++; $display("FAIL %s client_blocked got %0d busy cycles with grant/rd want 0", name, blk_bad); end

    pix_bad = 0; first_pix = -1;
    for (int w = 0; w < NWORDS; w++)
      for (int b = 0; b < 16; b++) begin
        want = rom[w][15 - b] ? FG : BG;
        if (res_mem[w * 16 + b] !== want) begin
          if (first_pix < 0) first_pix = w * 16 + b;
          pix_bad++;
        end
      end
    checks++; if (pix_bad != 0) begin
      failures++; $display("FAIL %s image got %0d bad pixels (first at %0d) want 0", name, pix_bad, first_pix); end
  endtask

  task automatic test_checkerboard();
    foreach (rom[i]) rom[i] = 16'hAAAA;
    // A second start pulse mid-load must be ignored; the latency check shows it.
    run_load("checker", $urandom_range(100, 15000));
    checks++; if (res_mem[0] !== FG)     begin failures++; $display("FAIL checker_px0 got %h want %h", res_mem[0], FG); end
    checks++; if (res_mem[1] !== BG)     begin failures++; $display("FAIL checker_px1 got %h want %h", res_mem[1], BG); end
    checks++; if (res_mem[16382] !== FG) begin failures++; $display("FAIL checker_px16382 got %h want %h", res_mem[16382], FG); end
    checks++; if (res_mem[16383] !== BG) begin failures++; $display("FAIL checker_px16383 got %h want %h", res_mem[16383], BG); end
  endtask

  task automatic test_sparse();
    int n;
    foreach (rom[i]) rom[i] = 16'h0000;
    rom[5] = 16'h8001;
    run_load("sparse", -1);
    n = 0;
    foreach (res_mem[i]) if (res_mem[i] !== BG) n++;
    checks++; if (res_mem[80] !== FG) begin failures++; $display("FAIL sparse_px80 got %h want %h", res_mem[80], FG); end
    checks++; if (res_mem[95] !== FG) begin failures++; $display("FAIL sparse_px95 got %h want %h", res_mem[95], FG); end
    checks++; if (res_mem[81] !== BG) begin failures++; $display("FAIL sparse_px81 got %h want %h", res_mem[81], BG); end
    checks++; if (n != 2) begin failures++; $display("FAIL sparse_fg_count got %0d want 2", n); end
  endtask

  task automatic test_reset_abort_and_reload();
    bit seen_done, bad;
    foreach (rom[i]) begin
      rom[i] = 16'($urandom);
`ifndef STI_ZERO_SKIP_EN
      if ($urandom_range(0, 7) == 0) rom[i] = 16'h0000;
`endif
    end
    rom[1023] = rom[1023] | 16'h0001;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4999) @(posedge clk);
    #1;
    bus.cl_req = 1'b1; bus.cl_we = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL abort_busy_done got %b/%b want 0/0", busy, done); end
    checks++; if (bus.sti_rd !== 1'b0 || bus.res_wr !== 1'b0 || bus.res_rd !== 1'b0) begin
      failures++; $display("FAIL abort_strobes got %b%b%b want 000", bus.sti_rd, bus.res_wr, bus.res_rd); end
    checks++; if (bus.cl_gnt !== 1'b0) begin failures++; $display("FAIL abort_cl_gnt got %b want 0", bus.cl_gnt); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL abort_state got %0d want IDLE", dbg_state); end
    seen_done = 1'b0; bad = 1'b0;
    repeat (3) begin @(negedge clk); seen_done |= done; end
    bus.cl_req = 1'b0;
    reset = 1'b1;
    repeat (4) begin @(negedge clk); seen_done |= done; bad |= busy; end
    checks++; if (seen_done || bad) begin
      failures++; $display("FAIL abort_no_done got done_seen=%b busy_seen=%b want 0/0", seen_done, bad); end

    // Reload with the client hammering writes at the last pixel: granted at
    // the start edge, locked out during the load, granted again right after.
    bus.cl_req = 1'b1; bus.cl_we = 1'b1; bus.cl_addr = 14'd16383;
    bus.cl_wdata = 8'($urandom_range(2, 255));
    run_load("reload", -1);
    checks++; if (bus.cl_gnt !== 1'b1) begin failures++; $display("FAIL grant_return got %b want 1", bus.cl_gnt); end
    bus.cl_req = 1'b0; bus.cl_we = 1'b0;
  endtask

`ifdef STI_ZERO_SKIP_EN
  task automatic test_zero_skip();
    foreach (rom[i]) rom[i] = 16'h0000;
    run_load("zero_skip", -1);
  endtask
`endif

  initial begin
    bus.cl_req = 1'b0; bus.cl_we = 1'b0; bus.cl_addr = '0; bus.cl_wdata = '0;
    bus.sti_di = '0; bus.res_di = '0;
    test_reset();
    test_client_rw(14'd100, 8'h3C);
    test_client_rw(14'($urandom_range(0, NPIX - 1)), 8'($urandom));
    test_checkerboard();
    test_sparse();
    test_reset_abort_and_reload();
`ifdef STI_ZERO_SKIP_EN
    test_zero_skip();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sti_res_loader.md
STI_RES_LOADER -- requirements
Module: sti_res_loader

Interface
REQ-001 SHALL have parameter FG_VAL, default 8'h01: value written to res memory for a set (foreground) stimulus bit.
REQ-002 SHALL have parameter BG_VAL, default 8'h00: value written for a clear (background) stimulus bit.
REQ-003 SHALL have port clk, input, 1: single clock; all state on posedge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: begin a load of one 128x128 image.
REQ-006 SHALL have ports busy and done, output, 1 each: load in progress; one-cycle completion pulse.
REQ-007 SHALL have ports sti_rd (output, 1), sti_addr (output, 10) and sti_di (input, 16): stimulus ROM read port; data is updated on negedge while sti_rd=1.
REQ-008 SHALL have ports res_wr (output, 1), res_rd (output, 1), res_addr (output, 14), res_do (output, 8) and res_di (input, 8): result RAM port; write on posedge, read data updated on negedge.
REQ-009 SHALL have ports cl_req, cl_we (input, 1), cl_addr (input, 14), cl_wdata (input, 8), cl_gnt (output, 1) and cl_rdata (output, 8): client access port to res memory.

Function
REQ-010 FSM states SHALL be IDLE, FETCH, UNPACK and DONE.
REQ-011 IDLE: start=1 at a posedge SHALL transition to FETCH with word index 0; start is ignored in all other states.
REQ-012 FETCH: SHALL drive sti_rd=1 and sti_addr=word index; at the next posedge SHALL latch sti_di into a 16-bit shift register, clear the bit counter and go to UNPACK.
REQ-013 UNPACK: SHALL assert res_wr=1 for exactly 16 cycles, with res_addr = {word index, bit counter} and res_do = FG_VAL if shift bit [15-bit counter] is set, else BG_VAL (MSB = leftmost pixel).
REQ-014 After bit counter 15: if word index < 1023, SHALL increment the word index and go to FETCH; otherwise SHALL go to DONE.
REQ-015 DONE: SHALL assert done=1 for one cycle and then return to IDLE.
REQ-016 busy SHALL be 1 in FETCH, UNPACK and DONE, and 0 in IDLE.
REQ-017 Without the configuration macro: 17 cycles per word; done SHALL assert 17409 cycles after the posedge that samples start.
REQ-018 Arbitration: the loader SHALL have absolute priority. While busy=1: cl_gnt=0, client inputs ignored, res_rd=0.
REQ-019 In IDLE: cl_gnt=cl_req (combinational); res_addr=cl_addr, res_wr=cl_req&cl_we, res_rd=cl_req&~cl_we, res_do=cl_wdata.
REQ-020 cl_rdata SHALL equal res_di; read data is valid at the posedge following the granted read cycle.
REQ-021 start and cl_req asserted in the same IDLE cycle: the client access SHALL be granted that cycle, and the loader SHALL enter FETCH at that edge.
REQ-022 The word index SHALL saturate at 1023 and SHALL never wrap during a load.

Reset
REQ-023 reset=0 SHALL immediately force IDLE, clear the word index, bit counter and shift register, and drive busy, done, sti_rd, res_wr, res_rd and cl_gnt to 0 (sti_addr, res_addr, res_do and cl_rdata to 0 / passthrough).
REQ-024 Reset mid-load SHALL abandon the load; already-written pixels are not restored; no done pulse is generated.

Configuration
REQ-025 Macro STI_ZERO_SKIP_EN defined: a latched word equal to 16'h0000 SHALL skip UNPACK and proceed straight to FETCH of the next word (or to DONE), costing 1 cycle per zero word; res memory holds BG_VAL there from prior clearing.
REQ-026 STI_ZERO_SKIP_EN undefined: every word SHALL be unpacked per REQ-013.

Structure
REQ-027 Package dt_pkg SHALL hold the state enum, STI_AW=10, RES_AW=14, IMG_W=128 and WORD_BITS=16.
REQ-028 SHALL be implemented as a single module with no sub-modules; the client/loader port mux is inline.

Verification
REQ-029 Checkerboard ROM (all words 16'hAAAA), start pulse -> res[0]=01, res[1]=00, ..., res[16383]=00; done exactly 17409 cycles after start; busy low afterwards.
REQ-030 ROM word 5 = 16'h8001, all other words 0 -> only res[80] and res[95] = 01.
REQ-031 Client write to addr 100 with data 8'h3C while idle, then read it back -> cl_gnt=1 both cycles; cl_rdata=3C.
REQ-032 cl_req held throughout a load -> cl_gnt=0 and no client writes while busy; grant returns the cycle after done.
REQ-033 reset asserted at cycle 5000 of a load -> outputs 0 immediately, no done pulse; a new start reloads the full image correctly.
REQ-034 With STI_ZERO_SKIP_EN and an all-zero ROM -> done 1025 cycles after start; no res_wr pulses.
